counter_control: RTL and testbench
==================================

# counter_control

Timer counting engine of the timer IP: turns the TCR control fields (load, up/down, enable, clock select) and the TDR value into an 8-bit count (TCNT) advancing on a prescaled tick. It owns the overflow/underflow flags and clears them on request from the status register. It sits beside `register_control`: it consumes `rc_tcr_*`, `rc_tdr_rdata` and `rc_clear_flag`, and drives `rc_ovf_flag` / `rc_udf_flag` back into it.

## Interface
- No parameters; all widths fixed at 8-bit count, 2-bit clock select.
- `cc_clk` in 1: single clock.
- `cc_reset_n` in 1: reset; asynchronous, active-low.
- `cc_load` in 1: TCR load bit; copy `cc_tdr` into TCNT.
- `cc_up_down` in 1: 0 = count up, 1 = count down.
- `cc_enable` in 1: TCR enable bit; counting permitted.
- `cc_cks` in 2: prescale select; 00 = /2, 01 = /4, 10 = /8, 11 = /16.
- `cc_tdr` in 8: load value (TDR contents).
- `cc_clear_flag` in 2: bit0 clears OVF, bit1 clears UDF; level-sensitive.
- `cc_tcnt` out 8: current count.
- `cc_ovf_flag` out 1: sticky overflow flag.
- `cc_udf_flag` out 1: sticky underflow flag.
- `cc_tick` out 1: one-cycle pulse on each cycle in which TCNT advances at the next edge.

## Operation
- States:
  - IDLE: hold TCNT; prescaler held at 0.
  - LOAD: TCNT <= `cc_tdr` every cycle; prescaler 0.
  - COUNT: prescaler runs; TCNT steps on tick.
  - HALT: entered only with the configuration macro; see Configuration.
- Transitions, evaluated every edge with priority load > enable:
  - `cc_load`=1 -> LOAD.
  - Else `cc_enable`=1 -> COUNT.
  - Else -> IDLE.
- Prescaler: 4-bit counter, N = 2^(cks+1).
  - In COUNT: increments 0..N-1, then wraps to 0.
  - `cc_tick` = (state==COUNT) && (prescaler==N-1), combinational.
  - Cleared to 0 outside COUNT and on any cycle where `cc_cks` differs from its registered previous value; no tick is issued in that cycle.
- Stepping on tick: up: TCNT+1 mod 256; down: TCNT-1 mod 256.
- Overflow: up step from 8'hFF -> TCNT=8'h00 and `cc_ovf_flag` <= 1.
- Underflow: down step from 8'h00 -> TCNT=8'hFF and `cc_udf_flag` <= 1.
- Flag clear: `cc_clear_flag[i]`=1 clears flag i at the edge.
  - A set and a clear of the same flag on the same edge: set wins.
  - The flag not addressed is unaffected.
- `cc_up_down` change mid-count: takes effect at the next tick; the prescaler is not reset.
- Load asserted on a tick cycle: load wins; no step, no flag.
- Reset values:
  - `cc_tcnt` = 8'h00.
  - `cc_ovf_flag` = 0, `cc_udf_flag` = 0, `cc_tick` = 0.
  - State = IDLE; prescaler = 0; registered cks = 2'b00.

## Timing
- Reset acts immediately and asynchronously on all registers; outputs are valid from the first edge after release.
- Load latency: `cc_load` sampled high at edge E -> `cc_tcnt` = `cc_tdr` after E.
- Count latency: enable sampled high at E0 (load low) -> first TCNT step at E0+N, then every N cycles.
- Flags assert on the same edge that TCNT wraps, with no extra latency.
- Clear takes effect at the sampling edge; the flag reads 0 in the following cycle.
- Enable deasserted: TCNT freezes at the sampling edge and the partial prescale count is discarded.

## Configuration
- `COUNTER_CONTROL_ONE_SHOT_EN`.
- Defined:
  - After the edge that sets OVF or UDF, the state goes to HALT.
  - In HALT, TCNT holds the wrapped value and no ticks are issued.
  - Exit from HALT:
    - `cc_load`=1 -> LOAD.
    - `cc_enable` sampled 0 -> IDLE; a subsequent enable re-arms counting.
- Undefined: the HALT state does not exist; the counter wraps and keeps counting (free-running).

## Test plan
- Reset mid-count with TCNT=8'h37 and OVF=1 -> all outputs reach their reset values immediately and asynchronously; after release with enable=0, TCNT stays 8'h00.
- Load: tdr=8'hA5, load pulsed for 1 cycle -> TCNT=8'hA5 next cycle. Then enable=1, up, cks=00 -> TCNT=8'hA6 at E0+2 and 8'hA7 at E0+4.
- Overflow: load 8'hFE, up, cks=01 -> 8'hFF after 4 cycles, 8'h00 after 8 cycles with OVF=1.
  - Without the macro: 8'h01 after 12 cycles.
  - With the macro: held at 8'h00.
- Underflow plus simultaneous clear: load 8'h00, down, cks=00, clear_flag=2'b10 held -> TCNT=8'hFF with UDF=1, because set wins; UDF is 0 one cycle after the next non-wrap edge.
- cks changed 11->00 at prescaler=7 -> no tick that cycle; next step exactly 2 cycles after the change edge.
- Load and tick coincident with tdr=8'h10 -> TCNT=8'h10, no step, flags unchanged.

Source files
------------

// File: rtl/counter_control.sv
// counter_control: 8-bit timer count engine, prescaled tick, sticky OVF/UDF flags.
// Option COUNTER_CONTROL_ONE_SHOT_EN: halt after a wrap until reload or disable.
module counter_control (
  input  logic       cc_clk,
  input  logic       cc_reset_n,
  input  logic       cc_load,
  input  logic       cc_up_down,
  input  logic       cc_enable,
  input  logic [1:0] cc_cks,
  input  logic [7:0] cc_tdr,
  input  logic [1:0] cc_clear_flag,
  output logic [7:0] cc_tcnt,
  output logic       cc_ovf_flag,
  output logic       cc_udf_flag,
  output logic       cc_tick
);

`ifdef COUNTER_CONTROL_ONE_SHOT_EN
  typedef enum logic [1:0] {
    IDLE, LOAD, COUNT, HALT
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, LOAD, COUNT
  } state_t;
`endif

  state_t     state;
  state_t     state_d;
  logic [3:0] pre;
  logic [3:0] pre_d;
  logic [3:0] last;
  logic [1:0] cks_q;
  logic [7:0] tcnt_d;
  logic       cks_chg;
  logic       step;
  logic       ovf_set;
  logic       udf_set;
  logic       ovf_d;
  logic       udf_d;

  // Terminal prescaler value for the selected divide ratio
  always_comb begin
    last = 4'd1;
    unique case (cc_cks)
      2'b00: last = 4'd1;
      2'b01: last = 4'd3;
      2'b10: last = 4'd7;
      2'b11: last = 4'd15;
    endcase
  end

  assign cks_chg = (cc_cks != cks_q);
  assign cc_tick = (state == COUNT) && !cks_chg
                && (pre == last);
  assign step    = cc_tick && !cc_load;
  assign ovf_set = step && !cc_up_down
                && (cc_tcnt == 8'hFF);
  assign udf_set = step && cc_up_down
                && (cc_tcnt == 8'h00);

  // Next state: load beats enable; one-shot parks in HALT after a wrap
  always_comb begin
    state_d = IDLE;
    if (cc_load)
      state_d = LOAD;
    else if (cc_enable)
      state_d = COUNT;
`ifdef COUNTER_CONTROL_ONE_SHOT_EN
    if (state == HALT && state_d == COUNT)
      state_d = HALT;
    if ((ovf_set || udf_set) && state_d == COUNT)
      state_d = HALT;
`endif
  end

  // Prescaler advances only while counting continues with a stable cks
  always_comb begin
    pre_d = pre + 4'd1;
    if (state_d != COUNT || state != COUNT
        || cks_chg || pre == last)
      pre_d = 4'd0;
  end

  // Count and flag next values; load wins over a step, set wins over clear
  always_comb begin
    tcnt_d = cc_tcnt;
    if (cc_load)
      tcnt_d = cc_tdr;
    else if (step)
      tcnt_d = cc_up_down ? cc_tcnt - 8'd1
                          : cc_tcnt + 8'd1;
    ovf_d = ovf_set
         || (cc_ovf_flag && !cc_clear_flag[0]);
    udf_d = udf_set
         || (cc_udf_flag && !cc_clear_flag[1]);
  end

  // State, prescaler and count registers
  always_ff @(posedge cc_clk or negedge cc_reset_n) begin
    if (!cc_reset_n) begin
      state       <= IDLE;
      pre         <= 4'd0;
      cks_q       <= 2'b00;
      cc_tcnt     <= 8'h00;
      cc_ovf_flag <= 1'b0;
      cc_udf_flag <= 1'b0;
    end else begin
      state       <= state_d;
      pre         <= pre_d;
      cks_q       <= cc_cks;
      cc_tcnt     <= tcnt_d;
      cc_ovf_flag <= ovf_d;
      cc_udf_flag <= udf_d;
    end
  end

endmodule

// File: tb/tb_counter_control.sv
// tb_counter_control: directed table, corner sequences and a
// randomized run against a behavioural timer model.
module tb_counter_control;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld = 1'b0;
  logic       ud = 1'b0;
  logic       en = 1'b0;
  logic [1:0] cks = 2'b00;
  logic [7:0] tdr = 8'h00;
  logic [1:0] clr = 2'b00;
  logic [7:0] tcnt;
  logic       ovf;
  logic       udf;
  logic       tick;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_control dut (
    .cc_clk       (clk),
    .cc_reset_n   (rst_n),
    .cc_load      (ld),
    .cc_up_down   (ud),
    .cc_enable    (en),
    .cc_cks       (cks),
    .cc_tdr       (tdr),
    .cc_clear_flag(clr),
    .cc_tcnt      (tcnt),
    .cc_ovf_flag  (ovf),
    .cc_udf_flag  (udf),
    .cc_tick      (tick)
  );

`ifdef COUNTER_CONTROL_ONE_SHOT_EN
  localparam logic [7:0] V20 = 8'h00;
  localparam logic [7:0] V26 = 8'hFF;
`else
  localparam logic [7:0] V20 = 8'h01;
  localparam logic [7:0] V26 = 8'hFE;
`endif

  typedef struct {
    logic       ld;
    logic       ud;
    logic       en;
    logic [1:0] cks;
    logic [7:0] tdr;
    logic [1:0] clr;
    logic [7:0] t;
    logic       o;
    logic       u;
  } vec_t;

  vec_t vq[$];

  function automatic void add(
    input logic l, input logic d, input logic e,
    input logic [1:0] c, input logic [7:0] v,
    input logic [1:0] cl, input logic [7:0] t,
    input logic o, input logic u);
    vec_t x;
    x.ld = l; x.ud = d; x.en = e; x.cks = c;
    x.tdr = v; x.clr = cl; x.t = t; x.o = o; x.u = u;
    vq.push_back(x);
  endfunction

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic l, input logic d,
                       input logic e, input logic [1:0] c,
                       input logic [7:0] v,
                       input logic [1:0] cl);
    @(negedge clk);
    ld = l; ud = d; en = e; cks = c; tdr = v; clr = cl;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // behavioural model state
  logic [7:0]  mt;
  logic        mo;
  logic        mu;
  logic        mrun;
  logic        mhalt;
  logic [1:0]  mcks;
  int unsigned me;

  initial begin
    logic        mtick;
    logic        mwrap;
    logic        nrun;
    logic        so;
    logic        su;
    int unsigned mn;

    #1;
    chk("rst_tcnt", tcnt, 8'h00);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_udf", udf, 1'b0);
    chk("rst_tick", tick, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // load, count up /2, overflow /4, underflow with held clear
    add(1,0,0,0,8'hA5,0, 8'hA5,0,0);
    add(0,0,1,0,8'hA5,0, 8'hA5,0,0);
    add(0,0,1,0,8'hA5,0, 8'hA5,0,0);
    add(0,0,1,0,8'hA5,0, 8'hA6,0,0);
    add(0,0,1,0,8'hA5,0, 8'hA6,0,0);
    add(0,0,1,0,8'hA5,0, 8'hA7,0,0);
    add(1,0,1,1,8'hFE,0, 8'hFE,0,0);
    for (int i = 0; i < 4; i++)
      add(0,0,1,1,8'h00,0, 8'hFE,0,0);
    for (int i = 0; i < 4; i++)
      add(0,0,1,1,8'h00,0, 8'hFF,0,0);
    for (int i = 0; i < 4; i++)
      add(0,0,1,1,8'h00,0, 8'h00,1,0);
    add(0,0,1,1,8'h00,0, V20,1,0);
    add(1,0,0,0,8'h00,0, 8'h00,1,0);
    add(0,1,1,0,8'h00,2, 8'h00,1,0);
    add(0,1,1,0,8'h00,2, 8'h00,1,0);
    add(0,1,1,0,8'h00,2, 8'hFF,1,1);
    add(0,1,1,0,8'h00,2, 8'hFF,1,0);
    add(0,1,1,0,8'h00,2, V26,1,0);
    add(0,1,0,0,8'h00,1, V26,0,0);
    add(0,1,0,0,8'h00,0, V26,0,0);

    foreach (vq[i]) begin
      drive(vq[i].ld, vq[i].ud, vq[i].en,
            vq[i].cks, vq[i].tdr, vq[i].clr);
      cyc();
      chk($sformatf("v%0d_tcnt", i), tcnt, vq[i].t);
      chk($sformatf("v%0d_ovf", i), ovf, vq[i].o);
      chk($sformatf("v%0d_udf", i), udf, vq[i].u);
    end

    // cks 11 -> 00 with prescaler at 7
    drive(1,0,0,3,8'h00,0); cyc();
    drive(0,0,1,3,8'h00,0); cyc();
    repeat (7) cyc();
    @(negedge clk);
    cks = 2'b00;
    #1 chk("cks_chg_tick", tick, 1'b0);
    cyc(); chk("cks_x0", tcnt, 8'h00);
    @(negedge clk);
    #1 chk("cks_x1_tick", tick, 1'b0);
    cyc(); chk("cks_x1", tcnt, 8'h00);
    @(negedge clk);
    #1 chk("cks_x2_tick", tick, 1'b1);
    cyc(); chk("cks_x2", tcnt, 8'h01);

    // load coincident with tick
    cyc();
    @(negedge clk);
    #1 chk("lt_tick", tick, 1'b1);
    ld = 1'b1; tdr = 8'h10;
    cyc();
    chk("lt_tcnt", tcnt, 8'h10);
    chk("lt_ovf", ovf, 1'b0);
    chk("lt_udf", udf, 1'b0);

    // asynchronous reset mid-count
    drive(1,0,1,0,8'hFF,0); cyc();
    drive(0,0,1,0,8'h00,0); cyc(); cyc(); cyc();
    chk("pre_rst_ovf", ovf, 1'b1);
    drive(1,0,1,0,8'h37,0); cyc();
    drive(0,0,1,0,8'h00,0); cyc();
    chk("pre_rst_tcnt", tcnt, 8'h37);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tcnt", tcnt, 8'h00);
    chk("arst_ovf", ovf, 1'b0);
    chk("arst_udf", udf, 1'b0);
    chk("arst_tick", tick, 1'b0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) cyc();
    chk("post_rst_tcnt", tcnt, 8'h00);

    // randomized run against the model
    drive(0,0,0,0,8'h00,0);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    mt = 8'h00; mo = 1'b0; mu = 1'b0;
    mrun = 1'b0; mhalt = 1'b0; mcks = 2'b00; me = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      ld = ($urandom % 20 == 0);
      if ($urandom % 10 == 0) en = ~en;
      if ($urandom % 8 == 0) ud = ~ud;
      if ($urandom % 40 == 0) cks = 2'($urandom);
      clr = ($urandom % 4 == 0) ? 2'($urandom) : 2'b00;
      case ($urandom % 5)
        0: tdr = 8'hFF;
        1: tdr = 8'hFE;
        2: tdr = 8'h00;
        3: tdr = 8'h01;
        default: tdr = 8'($urandom);
      endcase
      #1;
      mn = 2 << cks;
      mtick = mrun && (cks == mcks) && (me == mn - 1);
      if (!ld) chk("rnd_tick", tick, mtick);
      @(posedge clk);
      #1;
      so = 1'b0; su = 1'b0; mwrap = 1'b0;
      if (ld)
        mt = tdr;
      else if (mtick) begin
        if (!ud) begin
          so = (mt == 8'hFF);
          mt = mt + 8'd1;
        end else begin
          su = (mt == 8'h00);
          mt = mt - 8'd1;
        end
        mwrap = so || su;
      end
      mo = so || (mo && !clr[0]);
      mu = su || (mu && !clr[1]);
      nrun = !ld && en;
`ifdef COUNTER_CONTROL_ONE_SHOT_EN
      if (mhalt) begin
        nrun = 1'b0;
        if (ld || !en) mhalt = 1'b0;
      end else if (mwrap && nrun) begin
        mhalt = 1'b1;
        nrun = 1'b0;
      end
`endif
      if (nrun && mrun && cks == mcks && !mtick)
        me = me + 1;
      else
        me = 0;
      mrun = nrun;
      mcks = cks;
      chk("rnd_tcnt", tcnt, mt);
      chk("rnd_ovf", ovf, mo);
      chk("rnd_udf", udf, mu);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
